tpu_tile_ctrl: RTL and testbench

- Sequencer for the 4x4 systolic TPU: turns start and (m, k, n) into the full tiled matmul schedule.
- Issues read addresses to GBUFF_A and GBUFF_B, feeds and clears the PE array, waits for the array to drain, and writes result rows into GBUFF_OUT.
- Raises done when the last tile is written. It replaces ad-hoc sequencing in top.

---
 rtl/tpu_tile_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_tpu_tile_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/tpu_tile_ctrl.sv
// Tile sequencer for the 4x4 systolic array.
// It walks the (row tile, column tile) grid of an m x k x n matmul in row-major
// order. For each tile it streams k operand words from GBUFF_A and GBUFF_B,
// waits for the array to drain, and then writes the tile rows to GBUFF_OUT.
// Every output is registered. An output reflects the state that the FSM
// occupied on the previous clock edge.
module tpu_tile_ctrl #(
    parameter int ARRAY_SIZE = 4,
    parameter int DIM_W      = 4,
    parameter int ADDR_W     = 16,
    parameter int DRAIN_CYC  = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DIM_W-1:0]  m,
    input  logic [DIM_W-1:0]  k,
    input  logic [DIM_W-1:0]  n,
    output logic              a_rd_en,
    output logic [ADDR_W-1:0] a_rd_addr,
    output logic              b_rd_en,
    output logic [ADDR_W-1:0] b_rd_addr,
    output logic              pe_clear,
    output logic              pe_feed_valid,
    output logic              out_wr_en,
    output logic [ADDR_W-1:0] out_wr_addr,
    output logic [1:0]        out_row_sel,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        WRITE = 3'd4,
        NEXT  = 3'd5,
        DONE  = 3'd6
    } state_t;

    localparam logic [DIM_W-1:0]  ONE_D   = DIM_W'(1);
    localparam logic [DIM_W-1:0]  AS_D    = DIM_W'(ARRAY_SIZE);
    localparam logic [DIM_W:0]    AS_W    = (DIM_W+1)'(ARRAY_SIZE);
    localparam logic [DIM_W:0]    AS_M1_W = (DIM_W+1)'(ARRAY_SIZE - 1);
    localparam logic [ADDR_W-1:0] AS_A    = ADDR_W'(ARRAY_SIZE);
    localparam logic [DIM_W-1:0]  DRAIN_L = DIM_W'(DRAIN_CYC - 1);

    state_t            state_r;
    logic [DIM_W-1:0]  m_r;
    logic [DIM_W-1:0]  k_r;
    logic [DIM_W-1:0]  mt_r;
    logic [DIM_W-1:0]  nt_r;
    logic [DIM_W-1:0]  rt_r;
    logic [DIM_W-1:0]  ct_r;
    logic [DIM_W-1:0]  cnt_r;
    logic [DIM_W-1:0]  rem_s;
    logic [DIM_W-1:0]  rows_s;

    // Number of tiles needed to cover a dimension (ceiling division by the array size).
    function automatic logic [DIM_W-1:0] ceil_tiles(input logic [DIM_W-1:0] v);
        logic [DIM_W:0] sum;
        sum = {1'b0, v} + AS_M1_W;
        return DIM_W'(sum / AS_W);
    endfunction

    // Valid rows in the current row tile. The last row tile may be partial.
    always_comb begin
        rem_s  = m_r - (AS_D * rt_r);
        rows_s = AS_D;
        if (rem_s > AS_D) begin
            rows_s = AS_D;
        end else begin
            rows_s = rem_s;
        end
    end

    // Schedule FSM. It computes the next state and the registered outputs for this cycle's state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r       <= IDLE;
            m_r           <= '0;
            k_r           <= '0;
            mt_r          <= '0;
            nt_r          <= '0;
            rt_r          <= '0;
            ct_r          <= '0;
            cnt_r         <= '0;
            a_rd_en       <= 1'b0;
            a_rd_addr     <= '0;
            b_rd_en       <= 1'b0;
            b_rd_addr     <= '0;
            pe_clear      <= 1'b0;
            pe_feed_valid <= 1'b0;
            out_wr_en     <= 1'b0;
            out_wr_addr   <= '0;
            out_row_sel   <= 2'd0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            a_rd_en       <= 1'b0;
            a_rd_addr     <= '0;
            b_rd_en       <= 1'b0;
            b_rd_addr     <= '0;
            pe_clear      <= 1'b0;
            out_wr_en     <= 1'b0;
            out_wr_addr   <= '0;
            out_row_sel   <= 2'd0;
            busy          <= 1'b1;
            done          <= 1'b0;
            // The buffers have a one-cycle read latency, so feed valid trails the read enable.
            pe_feed_valid <= a_rd_en;
            case (state_r)
                IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        state_r <= LOAD;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                LOAD: begin
                    m_r   <= m;
                    k_r   <= k;
                    mt_r  <= ceil_tiles(m);
                    nt_r  <= ceil_tiles(n);
                    rt_r  <= '0;
                    ct_r  <= '0;
                    cnt_r <= '0;
                    if ((m == '0) || (k == '0) || (n == '0)) begin
                        state_r <= DONE;
                    end else begin
                        pe_clear <= 1'b1;
                        state_r  <= FEED;
                    end
                end
                FEED: begin
                    a_rd_en   <= 1'b1;
                    b_rd_en   <= 1'b1;
                    a_rd_addr <= (ADDR_W'(rt_r) * ADDR_W'(k_r)) + ADDR_W'(cnt_r);
                    b_rd_addr <= (ADDR_W'(ct_r) * ADDR_W'(k_r)) + ADDR_W'(cnt_r);
                    if (cnt_r == (k_r - ONE_D)) begin
                        cnt_r   <= '0;
                        state_r <= DRAIN;
                    end else begin
                        cnt_r <= cnt_r + ONE_D;
                    end
                end
                DRAIN: begin
                    if (cnt_r == DRAIN_L) begin
                        cnt_r   <= '0;
                        state_r <= WRITE;
                    end else begin
                        cnt_r <= cnt_r + ONE_D;
                    end
                end
                WRITE: begin
                    // The out-buffer data path zeroes the unused column lanes of a partial tile.
                    out_wr_en   <= 1'b1;
                    out_row_sel <= 2'(cnt_r);
                    out_wr_addr <= ((AS_A * ADDR_W'(rt_r)) + ADDR_W'(cnt_r)) * ADDR_W'(nt_r)
                                   + ADDR_W'(ct_r);
                    if (cnt_r == (rows_s - ONE_D)) begin
                        cnt_r   <= '0;
                        state_r <= NEXT;
                    end else begin
                        cnt_r <= cnt_r + ONE_D;
                    end
                end
                NEXT: begin
                    if ((rt_r == (mt_r - ONE_D)) && (ct_r == (nt_r - ONE_D))) begin
                        state_r <= DONE;
                    end else if (ct_r == (nt_r - ONE_D)) begin
                        ct_r     <= '0;
                        rt_r     <= rt_r + ONE_D;
                        pe_clear <= 1'b1;
                        state_r  <= FEED;
                    end else begin
                        ct_r     <= ct_r + ONE_D;
                        pe_clear <= 1'b1;
                        state_r  <= FEED;
                    end
                end
                DONE: begin
                    done <= 1'b1;
                    if (!start) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tpu_tile_ctrl.sv
// Testbench for tpu_tile_ctrl.
// For each job, a reference model builds the expected per-edge output record
// by walking the tile schedule with plain loops. The bench then checks every
// clock edge against that record.
module tb_tpu_tile_ctrl;

    typedef struct packed {
        logic        a_en;
        logic [15:0] a_addr;
        logic        b_en;
        logic [15:0] b_addr;
        logic        clr;
        logic        wr_en;
        logic [15:0] wr_addr;
        logic [1:0]  sel;
        logic        busy;
        logic        done;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  m = 4'd0;
    logic [3:0]  k = 4'd0;
    logic [3:0]  n = 4'd0;
    logic        a_rd_en, b_rd_en, pe_clear, pe_feed_valid, out_wr_en, busy, done;
    logic [15:0] a_rd_addr, b_rd_addr, out_wr_addr;
    logic [1:0]  out_row_sel;

    int   n_cmp = 0;
    int   n_fail = 0;
    logic prev_a = 1'b0;
    rec_t exp_q[$];

    tpu_tile_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .m            (m),
        .k            (k),
        .n            (n),
        .a_rd_en      (a_rd_en),
        .a_rd_addr    (a_rd_addr),
        .b_rd_en      (b_rd_en),
        .b_rd_addr    (b_rd_addr),
        .pe_clear     (pe_clear),
        .pe_feed_valid(pe_feed_valid),
        .out_wr_en    (out_wr_en),
        .out_wr_addr  (out_wr_addr),
        .out_row_sel  (out_row_sel),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic check_rec(input string tag, input rec_t e);
        rec_t o;
        o = {a_rd_en, a_rd_addr, b_rd_en, b_rd_addr, pe_clear, out_wr_en,
             out_wr_addr, out_row_sel, busy, done};
        n_cmp++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
        n_cmp++;
        assert (pe_feed_valid === prev_a) else begin
            n_fail++;
            $error("FAIL %s.feed_valid: observed %b expected %b", tag, pe_feed_valid, prev_a);
        end
        prev_a = e.a_en;
    endtask

    // Reference schedule. Entry 0 is the edge that samples start.
    task automatic build(input int mm, input int kd, input int nn);
        rec_t r;
        int   mt, nt, rows;
        exp_q.delete();
        r = '0;
        exp_q.push_back(r);
        r.busy = 1'b1;
        r.clr  = (mm != 0 && kd != 0 && nn != 0);
        exp_q.push_back(r);
        if (!r.clr) begin
            r = '0; r.busy = 1'b1; r.done = 1'b1;
            exp_q.push_back(r);
            return;
        end
        mt = (mm + 3) / 4;
        nt = (nn + 3) / 4;
        for (int rt = 0; rt < mt; rt++) begin
            for (int ct = 0; ct < nt; ct++) begin
                for (int kk = 0; kk < kd; kk++) begin
                    r = '0; r.busy = 1'b1; r.a_en = 1'b1; r.b_en = 1'b1;
                    r.a_addr = 16'(rt * kd + kk);
                    r.b_addr = 16'(ct * kd + kk);
                    exp_q.push_back(r);
                end
                for (int d = 0; d < 7; d++) begin
                    r = '0; r.busy = 1'b1;
                    exp_q.push_back(r);
                end
                rows = (mm - 4 * rt < 4) ? (mm - 4 * rt) : 4;
                for (int rr = 0; rr < rows; rr++) begin
                    r = '0; r.busy = 1'b1; r.wr_en = 1'b1;
                    r.wr_addr = 16'((4 * rt + rr) * nt + ct);
                    r.sel = 2'(rr);
                    exp_q.push_back(r);
                end
                r = '0; r.busy = 1'b1;
                r.clr = !(rt == mt - 1 && ct == nt - 1);
                exp_q.push_back(r);
            end
        end
        r = '0; r.busy = 1'b1; r.done = 1'b1;
        exp_q.push_back(r);
    endtask

    // Runs one job. The DUT must be in IDLE, and the call is made just after an edge.
    // The job ends one cycle after start drops, so the next call also covers a one-cycle start gap.
    task automatic run_job(input string nm, input int mm, input int kd, input int nn,
                           input int abort_at, input bit perturb);
        int wr_cnt, exp_wr;
        wr_cnt = 0;
        build(mm, kd, nn);
        m = 4'(mm); k = 4'(kd); n = 4'(nn);
        start = 1'b1;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i == abort_at) begin
                rst = 1'b0;
                start = 1'b0;
            end
            if (perturb && i == 3) begin
                m = 4'd15; k = 4'd15; n = 4'd15;
            end
            if (perturb && i == 4) start = 1'b0;
            if (perturb && i == 5) start = 1'b1;
            @(posedge clk);
            #1;
            if (i == abort_at) begin
                prev_a = 1'b0;
                check_rec($sformatf("%s.reset_abort", nm), '0);
                rst = 1'b1;
                return;
            end
            check_rec($sformatf("%s[%0d]", nm, i), exp_q[i]);
            if (out_wr_en) wr_cnt++;
        end
        @(posedge clk);
        #1;
        check_rec($sformatf("%s.done_hold", nm), exp_q[exp_q.size() - 1]);
        start = 1'b0;
        @(posedge clk);
        #1;
        check_rec($sformatf("%s.done_exit", nm), exp_q[exp_q.size() - 1]);
        exp_wr = (mm != 0 && kd != 0 && nn != 0) ? mm * ((nn + 3) / 4) : 0;
        n_cmp++;
        assert (wr_cnt === exp_wr) else begin
            n_fail++;
            $error("FAIL %s.wr_count: observed %0d expected %0d", nm, wr_cnt, exp_wr);
        end
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b1;
        m = 4'd4; k = 4'd4; n = 4'd4;
        repeat (3) @(posedge clk);
        #1;
        check_rec("reset_state", '0);
        start = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_rec("idle_after_reset", '0);

        run_job("basic444", 4, 4, 4, -1, 1'b0);
        run_job("m9k3n6", 9, 3, 6, -1, 1'b0);
        run_job("k_zero", 4, 0, 4, -1, 1'b0);
        run_job("abort_feed", 4, 4, 4, 5, 1'b0);
        run_job("restart444", 4, 4, 4, -1, 1'b0);
        run_job("m2k5n3", 2, 5, 3, -1, 1'b0);
        run_job("perturbed", 4, 4, 4, -1, 1'b1);
        run_job("full15", 15, 15, 15, -1, 1'b0);
        for (int j = 0; j < 12; j++) begin
            run_job($sformatf("rand%0d", j), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), -1, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
